// File: rtl/pwm_duty_controller_pkg.sv
// Shared types for the PWM duty controller: press FSM states, conf payload,
// step-select encoding and the step-size lookup.
package pwm_duty_controller_pkg;

  localparam int unsigned STEP_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } press_state_e;

  typedef enum logic [1:0] {
    STEP_1  = 2'b00,
    STEP_4  = 2'b01,
    STEP_16 = 2'b10,
    STEP_64 = 2'b11
  } step_sel_e;

  // conf[2] = auto-repeat enable, conf[1:0] = step select
  typedef struct packed {
    logic       rpt_en;
    logic [1:0] step_sel;
  } conf_t;

  // Step magnitude for a step-select code
  function automatic logic [STEP_W-1:0] step_size(input logic [1:0] sel);
    logic [STEP_W-1:0] s;
    case (step_sel_e'(sel))
      STEP_1:  s = STEP_W'(1);
      STEP_4:  s = STEP_W'(4);
      STEP_16: s = STEP_W'(16);
      STEP_64: s = STEP_W'(64);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pwm_duty_controller_if.sv
// Button/config inputs and duty outputs of the PWM duty controller.
//   master: drives ena, xu, xd, conf, period_end; observes duty outputs
//   slave : the controller itself
interface pwm_duty_controller_if
  import pwm_duty_controller_pkg::*;
#(
  parameter int unsigned DUTY_W = 8
);
  logic              ena;
  logic              xu;
  logic              xd;
  conf_t             conf;
  logic              period_end;
  logic [DUTY_W-1:0] duty;
  logic [DUTY_W-1:0] duty_pend;
  logic              update;
  logic              at_max;
  logic              at_min;

  modport master (
    output ena, xu, xd, conf, period_end,
    input  duty, duty_pend, update, at_max, at_min
  );

  modport slave (
    input  ena, xu, xd, conf, period_end,
    output duty, duty_pend, update, at_max, at_min
  );
endinterface

// File: rtl/pwm_btn_debounce.sv
// Button conditioner: 2-FF synchroniser followed by a debounce counter.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous bouncy button
//   level      : debounced level (flips after DEB_CYCLES consecutive
//                synchronised samples that differ from it)
module pwm_btn_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchroniser plus debounce; any sample equal to level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_controller.sv
// PWM duty controller: conditions the up/down buttons, runs the shared press
// FSM (single step, auto-repeat, lockout), keeps a saturating pending duty and
// publishes it to the PWM core only on a period boundary.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of pwm_duty_controller_if
//                (ena, xu, xd, conf, period_end in; duty, duty_pend, update,
//                 at_max, at_min out)
module pwm_duty_controller
  import pwm_duty_controller_pkg::*;
#(
  parameter int unsigned DUTY_W        = 8,
  parameter int unsigned RESET_DUTY    = 128,
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned REPEAT_DELAY  = 4096,
  parameter int unsigned REPEAT_PERIOD = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_duty_controller_if.slave  bus
);
  localparam int unsigned SUM_W   = (DUTY_W + 1 > STEP_W) ? DUTY_W + 1 : STEP_W;
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [SUM_W-1:0]  DUTY_MAX   = SUM_W'({DUTY_W{1'b1}});
  localparam logic [DUTY_W-1:0] DUTY_RST   = DUTY_W'(RESET_DUTY);
  localparam logic              RST_AT_MAX = (SUM_W'(DUTY_RST) == DUTY_MAX);
  localparam logic              RST_AT_MIN = (DUTY_RST == '0);

  press_state_e      state;
  logic              dir_up;
  logic [CNT_W-1:0]  cnt;
  logic              dirty;
  logic              up_lvl, dn_lvl;
  logic              up_q, dn_q;
  logic              up_rise, dn_rise;
  logic              act_c, oth_c;
  logic [CNT_W-1:0]  limit_c;
  logic [DUTY_W-1:0] step_val_c;

  // Saturating step, computed with one bit of headroom
  function automatic logic [DUTY_W-1:0] apply_step(input logic [DUTY_W-1:0] cur,
                                                   input logic up,
                                                   input logic [1:0] sel);
    logic [SUM_W-1:0] c;
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] r;
    c = SUM_W'(cur);
    s = SUM_W'(step_size(sel));
    if (up) begin
      r = c + s;
      if (r > DUTY_MAX) r = DUTY_MAX;
    end else begin
      r = (s > c) ? '0 : c - s;
    end
    return DUTY_W'(r);
  endfunction

  pwm_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.xu),
    .level (up_lvl)
  );

  pwm_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.xd),
    .level (dn_lvl)
  );

  assign up_rise = up_lvl & ~up_q;
  assign dn_rise = dn_lvl & ~dn_q;

  // Active/other button, repeat interval and the candidate stepped value
  always_comb begin
    act_c      = dir_up ? up_lvl : dn_lvl;
    oth_c      = dir_up ? dn_lvl : up_lvl;
    limit_c    = (state == ST_HOLD) ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
    step_val_c = apply_step(bus.duty_pend, (state == ST_IDLE) ? up_rise : dir_up,
                            bus.conf.step_sel);
  end

  // Press FSM, pending duty and period-boundary publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      dir_up        <= 1'b0;
      cnt           <= '0;
      dirty         <= 1'b0;
      up_q          <= 1'b0;
      dn_q          <= 1'b0;
      bus.duty      <= DUTY_RST;
      bus.duty_pend <= DUTY_RST;
      bus.update    <= 1'b0;
      bus.at_max    <= RST_AT_MAX;
      bus.at_min    <= RST_AT_MIN;
    end else begin
      up_q       <= up_lvl;
      dn_q       <= dn_lvl;
      bus.update <= 1'b0;

      // Publish takes the pre-step value; a same-cycle step re-sets dirty below
      if (bus.period_end && dirty) begin
        bus.duty   <= bus.duty_pend;
        bus.update <= 1'b1;
        dirty      <= 1'b0;
      end

      if (!bus.ena) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (up_rise && dn_rise) begin
              state <= ST_LOCK;
            end else if ((up_rise && !dn_lvl) || (dn_rise && !up_lvl)) begin
              dir_up        <= up_rise;
              state         <= ST_HOLD;
              bus.duty_pend <= step_val_c;
              bus.at_max    <= (SUM_W'(step_val_c) == DUTY_MAX);
              bus.at_min    <= (step_val_c == '0);
              if (step_val_c != bus.duty_pend) dirty <= 1'b1;
            end else if (up_lvl || dn_lvl) begin
              // A level already high without a fresh edge (e.g. ena just rose)
              state <= ST_LOCK;
            end
          end
          ST_HOLD, ST_REPEAT: begin
            if (oth_c) begin
              state <= ST_LOCK;
              cnt   <= '0;
            end else if (!act_c) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (bus.conf.rpt_en) begin
              if (cnt == limit_c) begin
                cnt           <= '0;
                state         <= ST_REPEAT;
                bus.duty_pend <= step_val_c;
                bus.at_max    <= (SUM_W'(step_val_c) == DUTY_MAX);
                bus.at_min    <= (step_val_c == '0);
                if (step_val_c != bus.duty_pend) dirty <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_LOCK: begin
            if (!up_lvl && !dn_lvl) state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_controller.sv
// Self-checking bench for pwm_duty_controller: scenario tasks push expected
// values into a scoreboard queue and pop them when the DUT result is due.
module tb_pwm_duty_controller;

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned DEB    = 16;
  localparam int unsigned RD     = 4096;
  localparam int unsigned RP     = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pwm_duty_controller_if #(.DUTY_W(DUTY_W)) bus ();

  pwm_duty_controller #(
    .DUTY_W        (DUTY_W),
    .RESET_DUTY    (128),
    .DEB_CYCLES    (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];
  int upd_cnt     = 0;
  int model       = 128;

  always @(posedge clk) if (bus.update === 1'b1) upd_cnt <= upd_cnt + 1;

  // Reference saturating step
  function automatic int ref_step(input int cur, input bit up, input int sel);
    int s;
    s = (sel == 0) ? 1 : (sel == 1) ? 4 : (sel == 2) ? 16 : 64;
    if (up) return (cur + s > 255) ? 255 : cur + s;
    return (cur - s < 0) ? 0 : cur - s;
  endfunction

  // Advance n clocks; time always ends 1 unit after a rising edge
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.xu         = 1'b0;
    bus.xd         = 1'b0;
    bus.period_end = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    model = 128;
  endtask

  task automatic press(input bit up, input int hold, input int settle);
    if (up) bus.xu = 1'b1; else bus.xd = 1'b1;
    cycles(hold);
    if (up) bus.xu = 1'b0; else bus.xd = 1'b0;
    cycles(settle);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.duty !== 8'd128) begin
      miscompares++; $display("FAIL reset_duty: got %0d expected 128", bus.duty);
    end
    vectors++;
    if (bus.duty_pend !== 8'd128) begin
      miscompares++; $display("FAIL reset_pend: got %0d expected 128", bus.duty_pend);
    end
    vectors++;
    if (bus.update !== 1'b0) begin
      miscompares++; $display("FAIL reset_update: got %b expected 0", bus.update);
    end
    vectors++;
    if (bus.at_max !== 1'b0 || bus.at_min !== 1'b0) begin
      miscompares++; $display("FAIL reset_limits: got max=%b min=%b expected 0 0", bus.at_max, bus.at_min);
    end
  endtask

  task automatic test_bounce();
    int e;
    bus.conf = 3'b000;
    exp_q.push_back(128);
    repeat (4) begin
      bus.xu = 1'b1; cycles(10);
      bus.xu = 1'b0; cycles(10);
    end
    cycles(20);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL bounce_reject: got %0d expected %0d", bus.duty_pend, e);
    end
    // Latency: unchanged after 18 edges, stepped after the 19th
    exp_q.push_back(128);
    exp_q.push_back(129);
    bus.xu = 1'b1;
    cycles(18);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL latency_edge18: got %0d expected %0d", bus.duty_pend, e);
    end
    cycles(1);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL latency_edge19: got %0d expected %0d", bus.duty_pend, e);
    end
    cycles(11);
    bus.xu = 1'b0;
    cycles(30);
    model = 129;
  endtask

  task automatic test_publish();
    int e;
    int upd0;
    upd0 = upd_cnt;
    cycles(50);
    vectors++;
    if (bus.duty !== 8'd128) begin
      miscompares++; $display("FAIL publish_hold: got %0d expected 128", bus.duty);
    end
    exp_q.push_back(model);
    bus.period_end = 1'b1; cycles(1); bus.period_end = 1'b0;
    e = exp_q.pop_front(); vectors++;
    if (bus.duty !== DUTY_W'(e) || bus.update !== 1'b1) begin
      miscompares++; $display("FAIL publish_load: got duty=%0d upd=%b expected %0d 1", bus.duty, bus.update, e);
    end
    cycles(1);
    vectors++;
    if (bus.update !== 1'b0) begin
      miscompares++; $display("FAIL publish_pulse: got update=%b expected 0", bus.update);
    end
    // A clean period_end must not pulse update again
    cycles(5);
    bus.period_end = 1'b1; cycles(1); bus.period_end = 1'b0;
    cycles(5);
    vectors++;
    if (upd_cnt - upd0 !== 1) begin
      miscompares++; $display("FAIL publish_once: got %0d pulses expected 1", upd_cnt - upd0);
    end
  endtask

  task automatic test_collide();
    int e;
    press(1'b1, 30, 30);
    model = ref_step(model, 1'b1, 0);
    exp_q.push_back(model);               // duty published on the collision
    exp_q.push_back(ref_step(model, 1'b1, 0));
    bus.xu = 1'b1;
    cycles(18);
    bus.period_end = 1'b1; cycles(1); bus.period_end = 1'b0;
    e = exp_q.pop_front(); vectors++;
    if (bus.duty !== DUTY_W'(e) || bus.update !== 1'b1) begin
      miscompares++; $display("FAIL collide_duty: got duty=%0d upd=%b expected %0d 1", bus.duty, bus.update, e);
    end
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL collide_pend: got %0d expected %0d", bus.duty_pend, e);
    end
    model = e;
    cycles(11);
    bus.xu = 1'b0;
    cycles(30);
    exp_q.push_back(model);
    bus.period_end = 1'b1; cycles(1); bus.period_end = 1'b0;
    e = exp_q.pop_front(); vectors++;
    if (bus.duty !== DUTY_W'(e) || bus.update !== 1'b1) begin
      miscompares++; $display("FAIL collide_later: got duty=%0d upd=%b expected %0d 1", bus.duty, bus.update, e);
    end
  endtask

  task automatic test_auto_repeat();
    int e;
    do_reset();
    bus.conf = 3'b101;
    exp_q.push_back(128 + 4 + 3 * 4);
    press(1'b1, RD + 3 * RP, 40);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL repeat_on: got %0d expected %0d", bus.duty_pend, e);
    end
    do_reset();
    bus.conf = 3'b001;
    exp_q.push_back(128 + 4);
    press(1'b1, RD + 3 * RP, 40);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL repeat_off: got %0d expected %0d", bus.duty_pend, e);
    end
  endtask

  task automatic test_saturation();
    int e;
    int up_sel[4] = '{3, 2, 1, 0};
    int up_n[4]   = '{1, 3, 2, 2};
    int dn_sel[3] = '{3, 2, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.conf = 3'(up_sel[i]);
      for (int k = 0; k < up_n[i]; k++) begin
        model = ref_step(model, 1'b1, up_sel[i]);
        exp_q.push_back(model);
        press(1'b1, 30, 30);
        e = exp_q.pop_front(); vectors++;
        if (bus.duty_pend !== DUTY_W'(e)) begin
          miscompares++; $display("FAIL climb_%0d_%0d: got %0d expected %0d", i, k, bus.duty_pend, e);
        end
      end
    end
    bus.conf = 3'b010;
    for (int k = 0; k < 2; k++) begin
      model = ref_step(model, 1'b1, 2);
      exp_q.push_back(model);
      press(1'b1, 30, 30);
      e = exp_q.pop_front(); vectors++;
      if (bus.duty_pend !== DUTY_W'(e) || bus.at_max !== 1'b1 || bus.at_min !== 1'b0) begin
        miscompares++; $display("FAIL sat_max_%0d: got %0d max=%b min=%b expected %0d 1 0",
                                k, bus.duty_pend, bus.at_max, bus.at_min, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      bus.conf = 3'(dn_sel[i]);
      for (int k = 0; k < 3; k++) begin
        model = ref_step(model, 1'b0, dn_sel[i]);
        exp_q.push_back(model);
        press(1'b0, 30, 30);
        e = exp_q.pop_front(); vectors++;
        if (bus.duty_pend !== DUTY_W'(e)) begin
          miscompares++; $display("FAIL descend_%0d_%0d: got %0d expected %0d", i, k, bus.duty_pend, e);
        end
      end
    end
    bus.conf = 3'b010;
    model = ref_step(model, 1'b0, 2);
    exp_q.push_back(model);
    press(1'b0, 30, 30);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e) || bus.at_min !== 1'b1 || bus.at_max !== 1'b0) begin
      miscompares++; $display("FAIL sat_min: got %0d min=%b max=%b expected %0d 1 0",
                              bus.duty_pend, bus.at_min, bus.at_max, e);
    end
  endtask

  task automatic test_simultaneous();
    int e;
    do_reset();
    bus.conf = 3'b000;
    exp_q.push_back(128);
    bus.xu = 1'b1; bus.xd = 1'b1;
    cycles(30);
    bus.xd = 1'b0;
    cycles(30);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL lock_hold: got %0d expected %0d", bus.duty_pend, e);
    end
    bus.xu = 1'b0;
    cycles(30);
    model = ref_step(128, 1'b1, 0);
    exp_q.push_back(model);
    press(1'b1, 30, 30);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL lock_exit: got %0d expected %0d", bus.duty_pend, e);
    end
  endtask

  task automatic test_enable();
    int e;
    bus.ena = 1'b0;
    exp_q.push_back(model);
    press(1'b1, 30, 30);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL ena_low: got %0d expected %0d", bus.duty_pend, e);
    end
    exp_q.push_back(model);
    bus.xu = 1'b1;
    cycles(30);
    bus.ena = 1'b1;
    cycles(30);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL ena_rise_held: got %0d expected %0d", bus.duty_pend, e);
    end
    bus.xu = 1'b0;
    cycles(30);
    model = ref_step(model, 1'b1, 0);
    exp_q.push_back(model);
    press(1'b1, 30, 30);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL ena_repress: got %0d expected %0d", bus.duty_pend, e);
    end
  endtask

  task automatic test_mid_reset();
    int e;
    do_reset();
    bus.conf = 3'b101;
    exp_q.push_back(128 + 4 + 4);
    bus.xu = 1'b1;
    cycles(RD + 200);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL pre_reset: got %0d expected %0d", bus.duty_pend, e);
    end
    rst_n  = 1'b0;
    bus.xu = 1'b0;
    #1;
    vectors++;
    if (bus.duty_pend !== 8'd128 || bus.duty !== 8'd128 || bus.update !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: got pend=%0d duty=%0d upd=%b expected 128 128 0",
                              bus.duty_pend, bus.duty, bus.update);
    end
    cycles(3);
    rst_n = 1'b1;
    cycles(40);
    vectors++;
    if (bus.duty_pend !== 8'd128) begin
      miscompares++; $display("FAIL post_reset: got %0d expected 128", bus.duty_pend);
    end
    exp_q.push_back(ref_step(128, 1'b1, 1));
    press(1'b1, 30, 30);
    e = exp_q.pop_front(); vectors++;
    if (bus.duty_pend !== DUTY_W'(e)) begin
      miscompares++; $display("FAIL post_reset_press: got %0d expected %0d", bus.duty_pend, e);
    end
  endtask

  initial begin
    bus.ena        = 1'b1;
    bus.xu         = 1'b0;
    bus.xd         = 1'b0;
    bus.conf       = 3'b000;
    bus.period_end = 1'b0;
    test_reset();
    test_bounce();
    test_publish();
    test_collide();
    test_auto_repeat();
    test_saturation();
    test_simultaneous();
    test_enable();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
